// File: rtl/matrix_pkg.sv
// Shared types, constants and width helper for the LED matrix scan sequencer.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam logic MODE_ROW_MAJOR = 1'b0;
  localparam logic MODE_COL_MAJOR = 1'b1;

  localparam int unsigned DEF_COLS  = 5;
  localparam int unsigned DEF_ROWS  = 7;
  localparam int unsigned DEF_SEL_W = 6;
  localparam int unsigned DEF_DWELL = 4;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/matrix_scan_if.sv
// Frame-source / demux-tree side signals of the matrix scan sequencer.
interface matrix_scan_if #(
  parameter int unsigned COLS  = matrix_pkg::DEF_COLS,
  parameter int unsigned ROWS  = matrix_pkg::DEF_ROWS,
  parameter int unsigned SEL_W = matrix_pkg::DEF_SEL_W
) ();

  localparam int unsigned CW = matrix_pkg::idx_w(COLS);
  localparam int unsigned RW = matrix_pkg::idx_w(ROWS);

  logic                 en;
  logic                 start;
  logic                 mode;
  logic [ROWS*COLS-1:0] pix_in;
  logic [CW-1:0]        col_idx;
  logic [RW-1:0]        row_idx;
  logic [SEL_W-1:0]     sel;
  logic                 sel_valid;
  logic                 pix_out;
  logic                 busy;
  logic                 frame_done;

  modport master (
    output en, start, mode, pix_in,
    input  col_idx, row_idx, sel, sel_valid, pix_out, busy, frame_done
  );

  modport slave (
    input  en, start, mode, pix_in,
    output col_idx, row_idx, sel, sel_valid, pix_out, busy, frame_done
  );

endinterface

// File: rtl/matrix_coord_counter.sv
// Nested column/row counter; traversal order picks which coordinate runs fastest.
module matrix_coord_counter
  import matrix_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS,
  localparam int unsigned CW  = idx_w(COLS),
  localparam int unsigned RW  = idx_w(ROWS)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          i_en,
  input  logic          i_clear,
  input  logic          i_adv,
  input  logic          i_mode,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col_adv_c,
  output logic [RW-1:0] o_row_adv_c,
  output logic          o_last_c
);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_end;
  logic          w_row_end;

  assign w_col_end = (r_col == CW'(COLS - 1));
  assign w_row_end = (r_row == RW'(ROWS - 1));
  assign o_last_c  = w_col_end & w_row_end;

  // Coordinates of the cell following the current one.
  always_comb begin
    o_col_adv_c = r_col;
    o_row_adv_c = r_row;
    if (i_mode == MODE_ROW_MAJOR) begin
      o_col_adv_c = w_col_end ? '0 : r_col + CW'(1);
      if (w_col_end) o_row_adv_c = w_row_end ? '0 : r_row + RW'(1);
    end else begin
      o_row_adv_c = w_row_end ? '0 : r_row + RW'(1);
      if (w_row_end) o_col_adv_c = w_col_end ? '0 : r_col + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (i_clear) begin
        r_col <= '0;
        r_row <= '0;
      end else if (i_adv) begin
        r_col <= o_col_adv_c;
        r_row <= o_row_adv_c;
      end
    end
  end

  assign o_col = r_col;
  assign o_row = r_row;

endmodule

// File: rtl/matrix_scan_sequencer.sv
// Steps a ROWS x COLS LED matrix cell by cell, driving demux select and latched pixel bit.
// Define MATRIX_SCAN_BLANK_EN to insert one anti-ghosting blank cycle after every cell.
module matrix_scan_sequencer
  import matrix_pkg::*;
#(
  parameter int unsigned COLS  = DEF_COLS,
  parameter int unsigned ROWS  = DEF_ROWS,
  parameter int unsigned SEL_W = DEF_SEL_W,
  parameter int unsigned DWELL = DEF_DWELL
) (
  input  logic          clk,
  input  logic          clr,
  matrix_scan_if.slave  bus
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned CW = idx_w(COLS);
  localparam int unsigned RW = idx_w(ROWS);
  localparam int unsigned DW = idx_w(DWELL);

  if ((64'(1) << SEL_W) < 64'(N)) begin : g_sel_w_check
    $error("matrix_scan_sequencer: SEL_W too narrow for ROWS*COLS");
  end

  function automatic logic [SEL_W-1:0] sel_of(input logic [CW-1:0] c, input logic [RW-1:0] r);
    return SEL_W'(r) * SEL_W'(COLS) + SEL_W'(c);
  endfunction

  scan_state_t      r_state, w_state_nxt;
  logic [DW-1:0]    r_dwell, w_dwell_nxt;
  logic [N-1:0]     r_frame, w_frame_nxt;
  logic             r_mode, w_mode_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_pix, w_pix_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
`ifdef MATRIX_SCAN_BLANK_EN
  logic             r_blank, w_blank_nxt;
  logic             r_fin, w_fin_nxt;
  logic [N-1:0]     w_cur_shift;
`endif

  logic             w_cnt_clear;
  logic             w_cnt_adv;
  logic             w_last;
  logic [CW-1:0]    w_col, w_col_adv;
  logic [RW-1:0]    w_row, w_row_adv;
  logic [SEL_W-1:0] w_sel_adv;
  logic [N-1:0]     w_adv_shift;

  matrix_coord_counter #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_coord (
    .clk         (clk),
    .clr         (clr),
    .i_en        (bus.en),
    .i_clear     (w_cnt_clear),
    .i_adv       (w_cnt_adv),
    .i_mode      (r_mode),
    .o_col       (w_col),
    .o_row       (w_row),
    .o_col_adv_c (w_col_adv),
    .o_row_adv_c (w_row_adv),
    .o_last_c    (w_last)
  );

  assign w_sel_adv   = sel_of(w_col_adv, w_row_adv);
  assign w_adv_shift = r_frame >> w_sel_adv;
`ifdef MATRIX_SCAN_BLANK_EN
  assign w_cur_shift = r_frame >> r_sel;
`endif

  assign w_sel_nxt = w_cnt_clear ? '0 : (w_cnt_adv ? w_sel_adv : r_sel);

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_dwell_nxt = r_dwell;
    w_frame_nxt = r_frame;
    w_mode_nxt  = r_mode;
    w_valid_nxt = r_valid;
    w_pix_nxt   = r_pix;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_clear = 1'b0;
    w_cnt_adv   = 1'b0;
`ifdef MATRIX_SCAN_BLANK_EN
    w_blank_nxt = r_blank;
    w_fin_nxt   = r_fin;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = SCAN;
          w_frame_nxt = bus.pix_in;
          w_mode_nxt  = bus.mode;
          w_dwell_nxt = '0;
          w_cnt_clear = 1'b1;
          w_valid_nxt = 1'b1;
          w_pix_nxt   = bus.pix_in[0];
          w_busy_nxt  = 1'b1;
        end
      end
      SCAN: begin
`ifdef MATRIX_SCAN_BLANK_EN
        if (r_blank) begin
          w_blank_nxt = 1'b0;
          if (r_fin) begin
            w_state_nxt = DONE;
            w_valid_nxt = 1'b0;
            w_pix_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
            w_cnt_clear = 1'b1;
          end else begin
            w_valid_nxt = 1'b1;
            w_pix_nxt   = w_cur_shift[0];
          end
        end else
`endif
        if (r_dwell == DW'(DWELL - 1)) begin
          w_dwell_nxt = '0;
          w_cnt_adv   = 1'b1;
`ifdef MATRIX_SCAN_BLANK_EN
          // Coordinates move on now; the cell lights one cycle later.
          w_blank_nxt = 1'b1;
          w_fin_nxt   = w_last;
          w_valid_nxt = 1'b0;
          w_pix_nxt   = 1'b0;
`else
          if (w_last) begin
            w_state_nxt = DONE;
            w_valid_nxt = 1'b0;
            w_pix_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
            w_cnt_clear = 1'b1;
          end else begin
            w_valid_nxt = 1'b1;
            w_pix_nxt   = w_adv_shift[0];
          end
`endif
        end else begin
          w_dwell_nxt = r_dwell + DW'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_pix_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_cnt_clear = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_pix_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_cnt_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_dwell <= '0;
      r_frame <= '0;
      r_mode  <= MODE_ROW_MAJOR;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_pix   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef MATRIX_SCAN_BLANK_EN
      r_blank <= 1'b0;
      r_fin   <= 1'b0;
`endif
    end else if (bus.en) begin
      r_state <= w_state_nxt;
      r_dwell <= w_dwell_nxt;
      r_frame <= w_frame_nxt;
      r_mode  <= w_mode_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
      r_pix   <= w_pix_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef MATRIX_SCAN_BLANK_EN
      r_blank <= w_blank_nxt;
      r_fin   <= w_fin_nxt;
`endif
    end
  end

  assign bus.col_idx    = w_col;
  assign bus.row_idx    = w_row;
  assign bus.sel        = r_sel;
  assign bus.sel_valid  = r_valid;
  assign bus.pix_out    = r_pix;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;

endmodule

// File: tb/tb_matrix_scan_sequencer.sv
// Directed bench for matrix_scan_sequencer at default geometry (5x7, DWELL=4).
module tb_matrix_scan_sequencer;

  localparam int unsigned COLS  = 5;
  localparam int unsigned ROWS  = 7;
  localparam int unsigned SEL_W = 6;
  localparam int unsigned DWELL = 4;
  localparam int unsigned N     = COLS * ROWS;
`ifdef MATRIX_SCAN_BLANK_EN
  localparam int BLANK = 1;
`else
  localparam int BLANK = 0;
`endif

  logic clk;
  logic clr;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   cyc_cnt = 0;

  matrix_scan_if #(.COLS(COLS), .ROWS(ROWS), .SEL_W(SEL_W)) bus ();

  matrix_scan_sequencer #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .SEL_W (SEL_W),
    .DWELL (DWELL)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  function automatic int exp_sel(input int k, input logic m);
    if (!m) return k;
    return (k % ROWS) * COLS + (k / ROWS);
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(bus.sel_valid), 64'(0));
    chk({tag, "_busy"},  64'(bus.busy),      64'(0));
    chk({tag, "_done"},  64'(bus.frame_done), 64'(0));
    chk({tag, "_sel"},   64'(bus.sel),       64'(0));
    chk({tag, "_pix"},   64'(bus.pix_out),   64'(0));
    chk({tag, "_col"},   64'(bus.col_idx),   64'(0));
    chk({tag, "_row"},   64'(bus.row_idx),   64'(0));
  endtask

  // One full frame; stray starts, mid-frame input changes and an enable freeze are optional.
  task automatic scan_frame(input logic m, input logic [N-1:0] frame,
                            input int stray_a, input int stray_b,
                            input int fz_cell, input int fz_len);
    int t0, s, c, r, cyc;
    logic [N-1:0] f;
    f = frame;
    bus.mode   = m;
    bus.pix_in = frame;
    bus.start  = 1'b1;
    t0 = cyc_cnt;
    tick();
    bus.start  = 1'b0;
    bus.pix_in = ~frame;
    bus.mode   = ~m;
    cyc = 1;
    for (int k = 0; k < int'(N); k++) begin
      s = exp_sel(k, m);
      c = s % COLS;
      r = s / COLS;
      for (int d = 0; d < int'(DWELL); d++) begin
        chk("sel",   64'(bus.sel),        64'(s));
        chk("col",   64'(bus.col_idx),    64'(c));
        chk("row",   64'(bus.row_idx),    64'(r));
        chk("valid", 64'(bus.sel_valid),  64'(1));
        chk("pix",   64'(bus.pix_out),    64'(f[s]));
        chk("busy",  64'(bus.busy),       64'(1));
        chk("done",  64'(bus.frame_done), 64'(0));
        if (k == fz_cell && d == 2 && fz_len > 0) begin
          bus.en = 1'b0;
          repeat (fz_len) begin
            tick();
            chk("frz_sel",   64'(bus.sel),       64'(s));
            chk("frz_valid", 64'(bus.sel_valid), 64'(1));
            chk("frz_pix",   64'(bus.pix_out),   64'(f[s]));
          end
          bus.en = 1'b1;
        end
        bus.start = (cyc == stray_a || cyc == stray_b);
        tick();
        cyc++;
        bus.start = 1'b0;
      end
`ifdef MATRIX_SCAN_BLANK_EN
      chk("blank_valid", 64'(bus.sel_valid), 64'(0));
      chk("blank_pix",   64'(bus.pix_out),   64'(0));
      chk("blank_sel",   64'(bus.sel),       64'(exp_sel((k + 1) % int'(N), m)));
      tick();
      cyc++;
`endif
    end
    chk("fin_done",    64'(bus.frame_done), 64'(1));
    chk("fin_busy",    64'(bus.busy),       64'(1));
    chk("fin_valid",   64'(bus.sel_valid),  64'(0));
    chk("fin_sel",     64'(bus.sel),        64'(0));
    chk("fin_col",     64'(bus.col_idx),    64'(0));
    chk("fin_row",     64'(bus.row_idx),    64'(0));
    chk("fin_latency", 64'(cyc_cnt - t0),   64'(int'(N) * (int'(DWELL) + BLANK) + 1 + fz_len));
    tick();
    chk("post_done",  64'(bus.frame_done), 64'(0));
    chk("post_busy",  64'(bus.busy),       64'(0));
    chk("post_valid", 64'(bus.sel_valid),  64'(0));
  endtask

  initial begin
    clr        = 1'b0;
    bus.en     = 1'b1;
    bus.start  = 1'b0;
    bus.mode   = 1'b0;
    bus.pix_in = '0;

    // Reset state, then quiet until a start arrives.
    #3;
    chk_idle("rst");
    tick();
    #1 clr = 1'b1;
    repeat (3) tick();
    chk_idle("idle");

    // Start with enable low is lost.
    bus.en     = 1'b0;
    bus.start  = 1'b1;
    bus.pix_in = '1;
    tick();
    bus.start  = 1'b0;
    bus.en     = 1'b1;
    tick();
    chk_idle("en_lost");

    scan_frame(1'b0, 35'h0_0000_0001, -1, -1, -1, 0);
    scan_frame(1'b1, 35'h4_A5C3_96E1, -1, -1, -1, 0);
    scan_frame(1'b0, 35'h2_D3B1_0F5A, 10, 50, -1, 0);
    scan_frame(1'b0, 35'h7_FFFF_0000, -1, -1, 3, 7);

    // Reset mid-frame clears outputs without waiting for a clock edge.
    bus.mode   = 1'b0;
    bus.pix_in = '1;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    repeat (12 * (DWELL + BLANK)) tick();
    chk("mid_sel", 64'(bus.sel),  64'(12));
    chk("mid_busy", 64'(bus.busy), 64'(1));
    #1 clr = 1'b0;
    #1;
    chk_idle("mid_rst");
    #2 clr = 1'b1;
    repeat (5) tick();
    chk_idle("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/matrix_scan_sequencer.md
Name: matrix_scan_sequencer

Overview:
- Parametrised successor to the 1:16 demux selector.
- Steps a column/row coordinate pair across a ROWS x COLS LED matrix.
- Converts the current cell to a linear demux select index.
- Latches a full frame of pixel bits at start and drives the pixel bit of the current cell.
- Sits between the frame source and the demux/driver tree of the display.

Parameters:
COLS, 5, matrix column count (>=2)
ROWS, 7, matrix row count (>=2)
SEL_W, 6, demux select width; elaboration error if 2**SEL_W < ROWS*COLS
DWELL, 4, clock cycles each cell stays selected (>=1)

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-low reset
en  in  1  clock enable for the scan; low freezes all state
start  in  1  one-cycle request to begin a frame; honoured only in IDLE
mode  in  1  0 = row-major traversal (col fastest), 1 = column-major (row fastest); sampled at start
pix_in  in  ROWS*COLS  frame bits, index = row*COLS+col; sampled at start
col_idx  out  clog2(COLS)  current column
row_idx  out  clog2(ROWS)  current row
sel  out  SEL_W  linear demux select = row_idx*COLS+col_idx
sel_valid  out  1  sel/pix_out are meaningful this cycle
pix_out  out  1  latched pixel bit of current cell
busy  out  1  high in SCAN and DONE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (clr=0, async):
  - state=IDLE; col_idx=0, row_idx=0, sel=0.
  - sel_valid=0, pix_out=0, busy=0, frame_done=0.
  - Dwell counter=0; frame register=0; latched mode=0.
- All registered; outputs change only on clk rising edge (except async clear).
- en=0: state, counters and outputs hold; a start pulse arriving while en=0 is lost.
- FSM states IDLE, SCAN, DONE.
  - IDLE:
    - start=1 & en=1: latch pix_in and mode; col=row=0; dwell=0; -> SCAN.
    - sel_valid asserts the next cycle, i.e. one cycle of latency from start.
  - SCAN:
    - sel_valid=1; pix_out=frame[sel].
    - Dwell counts 0..DWELL-1. At DWELL-1, advance the cell and reset dwell to 0.
    - Row-major advance: col++; at col=COLS-1, col=0 and row++.
    - Column-major advance: row++; at row=ROWS-1, row=0 and col++.
    - Last cell (row=ROWS-1, col=COLS-1) at dwell DWELL-1 -> DONE.
  - DONE:
    - Exactly one cycle; frame_done=1; sel_valid=0; col=row=0; -> IDLE.
- A frame occupies ROWS*COLS*DWELL SCAN cycles plus 1 DONE cycle.
- start during SCAN or DONE: ignored; frame register is not overwritten.
- pix_in and mode changes mid-frame have no effect.
- sel never exceeds ROWS*COLS-1. Arithmetic is unsigned and computed in SEL_W bits.
- Reset mid-frame: immediate return to IDLE; the partial frame is discarded.
- DWELL=1: a new cell every cycle; the counter stays 0.

Optional Feature:
- Macro: MATRIX_SCAN_BLANK_EN.
- When defined:
  - One blanking cycle is inserted after each cell's dwell, before the next cell (including before DONE).
  - During that cycle sel_valid=0 and pix_out=0; col/row already hold the next cell.
  - Purpose: anti-ghosting.
  - Frame length becomes ROWS*COLS*(DWELL+1) SCAN cycles plus 1 DONE cycle.
- When undefined: no blanking; behaviour exactly as above.

Decomposition:
- Shared package matrix_pkg holds:
  - scan_state_t enum {IDLE, SCAN, DONE}
  - mode constants MODE_ROW_MAJOR=0, MODE_COL_MAJOR=1
  - default COLS/ROWS/DWELL constants
  - clog2-based width helper function
- One sub-module, matrix_coord_counter:
  - Nested col/row counter with wrap and last-cell flag.
  - Traversal order selected by mode.
  - Parameters COLS and ROWS.

Test Plan:
- Reset: clr=0 mid-SCAN at sel=12 -> same cycle all outputs 0, state IDLE; after release, no activity until start.
- Row-major, defaults, pix_in=35'h1: start -> sel sequence 0,1,2,...,34, each held 4 cycles; pix_out=1 only while sel=0; frame_done pulses once, 141 cycles after start.
- Column-major: mode=1 -> sel sequence 0,5,10,15,20,25,30,1,6,...,34; col_idx/row_idx consistent with sel at every cell.
- Start ignored: start pulses at cycles 10 and 50 of a running frame -> no restart; frame completes in 141 cycles; pix_out follows the originally latched frame.
- Enable freeze: en=0 for 7 cycles at sel=3, dwell=2 -> all outputs hold; resumes at dwell=3; total frame time extended by exactly 7 cycles.
- MATRIX_SCAN_BLANK_EN, DWELL=1, COLS=2, ROWS=2 -> sel_valid pattern 1,0,1,0,1,0,1,0 then frame_done; pix_out=0 during the 0 cycles.
